// File: rtl/round_pack.sv
// Post-add normalization, round-to-nearest-even and packing stage of the FPU add path.
// Renormalizes one bit per cycle; one operation in flight, valid/ready on both sides.
module round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+3:0]   in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W-1:0]   out_frac,
  output logic               out_zero,
  output logic               out_inexact,
  output logic               out_overflow
);

  localparam int MW = MAN_W + 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic             sign_r;
  logic [EXP_W-1:0] exp_r;
  logic [MW-1:0]    mant_r;

  logic             rnd_inc;
  logic [MAN_W+1:0] rnd_sum;
  logic [MAN_W:0]   rnd_hf;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_ovf;
  logic [MAN_W-1:0] rnd_frac;
  logic             rnd_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Round datapath, evaluated from the working registers while in ROUND.
  always_comb begin
    rnd_inc = mant_r[1] & (mant_r[0] | mant_r[2]);
    rnd_sum = {1'b0, mant_r[MW-2:2]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    rnd_exp = exp_r;
    if (rnd_sum[MAN_W+1]) begin
      rnd_hf = rnd_sum[MAN_W+1:1];
      // A SHIFT-stage carry may already have saturated the exponent.
      if (exp_r != '1)
        rnd_exp = exp_r + 1'b1;
    end else begin
      rnd_hf = rnd_sum[MAN_W:0];
    end
    if (rnd_exp == '0 && rnd_hf[MAN_W])
      rnd_exp = {{(EXP_W-1){1'b0}}, 1'b1};
    rnd_ovf  = (rnd_exp == '1);
    rnd_frac = rnd_ovf ? '0 : rnd_hf[MAN_W-1:0];
    rnd_zero = !rnd_ovf && (rnd_exp == '0) && (rnd_hf == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      mant_r       <= '0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_zero     <= 1'b0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (exp_r == '1) begin
            out_sign     <= sign_r;
            out_exp      <= '1;
            out_frac     <= mant_r[MW-3:2];
            out_zero     <= 1'b0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            state        <= DONE;
          end else if (mant_r == '0) begin
            out_sign     <= sign_r;
            out_exp      <= '0;
            out_frac     <= '0;
            out_zero     <= 1'b1;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            state        <= DONE;
          end else if (mant_r[MW-1]) begin
            // Right shift folds both guard and sticky into the new sticky.
            mant_r <= {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + 1'b1;
            state  <= ROUND;
          end else if (mant_r[MW-2]) begin
            state <= ROUND;
          end else if (exp_r > {{(EXP_W-1){1'b0}}, 1'b1}) begin
            mant_r <= {mant_r[MW-2:0], 1'b0};
            exp_r  <= exp_r - 1'b1;
          end else begin
            exp_r <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          out_sign     <= sign_r;
          out_exp      <= rnd_exp;
          out_frac     <= rnd_frac;
          out_zero     <= rnd_zero;
          out_inexact  <= mant_r[1] | mant_r[0];
          out_overflow <= rnd_ovf;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_pack.sv
// Directed bench for round_pack: vector table plus backpressure and mid-operation reset sequences.
module tb_round_pack;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_inexact;
  logic        out_overflow;

  int checks = 0;
  int failures = 0;

  round_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_zero(out_zero), .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic [7:0]  r_exp;
    logic [22:0] r_frac;
    logic        r_zero;
    logic        r_inexact;
    logic        r_ovf;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one operation; returns cycles from accept edge to out_valid (limit on timeout).
  task automatic issue(input logic s, input logic [7:0] e, input logic [26:0] m, output int lat);
    @(negedge clock);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [7:0]  h_exp;
    logic [22:0] h_frac;

    vecs[0]  = '{1'b0, 8'h7F, 27'h2000000, 8'h7F, 23'h000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 8'h7F, 27'h4000004, 8'h80, 23'h000000, 1'b0, 1'b1, 1'b0, 2};
    vecs[2]  = '{1'b1, 8'h7F, 27'h0400000, 8'h7C, 23'h000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b0, 8'h7F, 27'h3FFFFFE, 8'h80, 23'h000000, 1'b0, 1'b1, 1'b0, 2};
    vecs[4]  = '{1'b0, 8'hFE, 27'h4000000, 8'hFF, 23'h000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[5]  = '{1'b1, 8'h40, 27'h0000000, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, 8'hFF, 27'h2000010, 8'hFF, 23'h000004, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 8'h7F, 27'h2000006, 8'h7F, 23'h000002, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{1'b0, 8'h02, 27'h0400000, 8'h00, 23'h200000, 1'b0, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, 8'h01, 27'h1FFFFFE, 8'h01, 23'h000000, 1'b0, 1'b1, 1'b0, 2};
    vecs[10] = '{1'b1, 8'hFE, 27'h3FFFFFE, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b1, 2};

    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data", {out_sign, out_exp, out_frac}, 32'd0);
    check("reset_flags", {out_zero, out_inexact, out_overflow}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].sign, vecs[i].exp, vecs[i].mant, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_sign", i), 32'(out_sign), 32'(vecs[i].sign));
      check($sformatf("v%0d_exp", i), 32'(out_exp), 32'(vecs[i].r_exp));
      check($sformatf("v%0d_frac", i), 32'(out_frac), 32'(vecs[i].r_frac));
      check($sformatf("v%0d_flags", i), {out_zero, out_inexact, out_overflow},
            {vecs[i].r_zero, vecs[i].r_inexact, vecs[i].r_ovf});
      check($sformatf("v%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_back_idle", i), {out_valid, in_ready}, 32'b01);
    end

    // Backpressure on a zero result; in_valid held high must be ignored.
    out_ready = 1'b0;
    issue(1'b1, 8'h33, 27'h0, lat);
    check("bp_latency", 32'(lat), 32'd1);
    check("bp_zero", 32'(out_zero), 32'd1);
    h_exp = out_exp;
    h_frac = out_frac;
    in_valid = 1'b1;
    in_mant = 27'h2000000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("bp_hold%0d_valid", c), {out_valid, in_ready}, 32'b10);
      check($sformatf("bp_hold%0d_data", c), {out_zero, out_sign, out_exp, out_frac},
            {1'b1, 1'b1, h_exp, h_frac});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release", {out_valid, in_ready}, 32'b01);

    // Reset during the second SHIFT cycle of the 3-shift cancellation case.
    @(negedge clock);
    in_sign = 1'b0; in_exp = 8'h7F; in_mant = 27'h0400000; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (out_valid) lat++;
    end
    check("rst_mid_no_pulse", 32'(lat), 32'd0);
    check("rst_mid_data", {out_zero, out_inexact, out_overflow, out_exp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
